// File: rtl/main_sys_pkg.sv
// main_sys_pkg
//   Shared types and default constants for the main-CPU system controller.
//   - wdt_state_e   : watchdog FSM states
//   - NMI_LINE_DEF  : default vertical line that raises the V-blank NMI
//   - SNDRQ_LEN_DEF : default sound-request pulse length in CE strikes
package main_sys_pkg;

  typedef enum logic [1:0] {
    WDT_IDLE  = 2'd0,
    WDT_COUNT = 2'd1,
    WDT_FIRE  = 2'd2
  } wdt_state_e;

  localparam int NMI_LINE_DEF  = 241;
  localparam int SNDRQ_LEN_DEF = 4;

endpackage

// File: rtl/main_sys_if.sv
// main_sys_if
//   CPU-side bus bundle of the main system controller.
//   master : CPU decoder / video timing side (drives strobes, selects, data, counters, ack)
//   slave  : main_sys_ctrl (drives LATCH, SNDNO, SNDRQ, SNDOVF, NMI, WDT_RST)
interface main_sys_if #(
  parameter int LATCH_BITS = 8
);
  localparam int AW = (LATCH_BITS > 1) ? $clog2(LATCH_BITS) : 1;

  logic                  CE;
  logic                  WR;
  logic                  SEL_WDT;
  logic                  SEL_SRQ;
  logic                  SEL_SNO;
  logic                  SEL_LAT;
  logic [AW-1:0]         LAT_AD;
  logic [7:0]            DIN;
  logic [8:0]            PH;
  logic [8:0]            PV;
  logic                  SNDACK;
  logic [LATCH_BITS-1:0] LATCH;
  logic [7:0]            SNDNO;
  logic                  SNDRQ;
  logic                  SNDOVF;
  logic                  NMI;
  logic                  WDT_RST;

  modport master (
    output CE, WR, SEL_WDT, SEL_SRQ, SEL_SNO, SEL_LAT, LAT_AD, DIN, PH, PV, SNDACK,
    input  LATCH, SNDNO, SNDRQ, SNDOVF, NMI, WDT_RST
  );

  modport slave (
    input  CE, WR, SEL_WDT, SEL_SRQ, SEL_SNO, SEL_LAT, LAT_AD, DIN, PH, PV, SNDACK,
    output LATCH, SNDNO, SNDRQ, SNDOVF, NMI, WDT_RST
  );

endinterface

// File: rtl/main_wdt.sv
// main_wdt
//   Watchdog: counts CE strikes, fires a held reset request when the count
//   reaches WDT_LIMIT, then re-arms.
//   Ports: MCLK (clock), RESET_N (async active-low reset), CE (strike enable),
//          KICK (qualified watchdog write), WDT_RST (registered reset request).
module main_wdt
  import main_sys_pkg::*;
#(
  parameter int                  WDT_BITS    = 20,
  parameter logic [WDT_BITS-1:0] WDT_LIMIT   = {WDT_BITS{1'b1}},
  parameter int                  WDT_RST_LEN = 16
) (
  input  logic MCLK,
  input  logic RESET_N,
  input  logic CE,
  input  logic KICK,
  output logic WDT_RST
);

  // The counter holds the number of strikes already counted, so the strike
  // that would make it equal to the limit is the firing strike.
  localparam logic [WDT_BITS-1:0] CNT_LAST  = WDT_LIMIT - WDT_BITS'(1);
  localparam logic [WDT_BITS-1:0] HOLD_LAST = WDT_BITS'(WDT_RST_LEN - 1);

  wdt_state_e          r_state;
  wdt_state_e          w_state_nxt;
  logic [WDT_BITS-1:0] r_cnt;
  logic [WDT_BITS-1:0] w_cnt_nxt;
  logic                r_rst;
  logic                w_rst_nxt;

  // State, counter and reset-request registers; advance only on a CE strike.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= WDT_IDLE;
      r_cnt   <= '0;
      r_rst   <= 1'b0;
    end else if (CE) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
    end
  end

  // Next-state logic. IDLE behaves as COUNT so the first strike is counted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst;
    case (r_state)
      WDT_IDLE, WDT_COUNT: begin
        if (KICK) begin
          w_state_nxt = WDT_COUNT;
          w_cnt_nxt   = '0;
          w_rst_nxt   = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = WDT_FIRE;
          w_cnt_nxt   = '0;
          w_rst_nxt   = 1'b1;
        end else begin
          w_state_nxt = WDT_COUNT;
          w_cnt_nxt   = r_cnt + WDT_BITS'(1);
          w_rst_nxt   = 1'b0;
        end
      end
      WDT_FIRE: begin
        // Kicks are ignored here; the counter measures the hold time.
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = WDT_COUNT;
          w_cnt_nxt   = '0;
          w_rst_nxt   = 1'b0;
        end else begin
          w_state_nxt = WDT_FIRE;
          w_cnt_nxt   = r_cnt + WDT_BITS'(1);
          w_rst_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = WDT_IDLE;
        w_cnt_nxt   = '0;
        w_rst_nxt   = 1'b0;
      end
    endcase
  end

  assign WDT_RST = r_rst;

endmodule

// File: rtl/main_sys_ctrl.sv
// main_sys_ctrl
//   Main-CPU glue: addressable control latch, watchdog, sound-command mailbox
//   and V-blank NMI generator. All state advances only on a CE strike.
//   Ports: MCLK (master clock), RESET_N (async active-low reset),
//          bus (main_sys_if.slave: CE, WR, selects, LAT_AD, DIN, PH, PV, SNDACK
//               in; LATCH, SNDNO, SNDRQ, SNDOVF, NMI, WDT_RST out).
//   Build option: define MAIN_SNDACK_EN to make SNDRQ a level held until
//   SNDACK; otherwise SNDRQ is a SNDRQ_LEN-strike pulse and SNDACK is ignored.
module main_sys_ctrl
  import main_sys_pkg::*;
#(
  parameter int                  LATCH_BITS   = 8,
  parameter int                  WDT_BITS     = 20,
  parameter logic [WDT_BITS-1:0] WDT_LIMIT    = WDT_BITS'(20'hFFFFF),
  parameter int                  WDT_RST_LEN  = 16,
  parameter int                  SNDRQ_LEN    = SNDRQ_LEN_DEF,
  parameter int                  NMI_LINE     = NMI_LINE_DEF,
  parameter int                  NMI_MASK_BIT = 0
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  main_sys_if.slave  bus
);

  localparam int AW = (LATCH_BITS > 1) ? $clog2(LATCH_BITS) : 1;

  logic w_wr_wdt;
  logic w_wr_srq;
  logic w_wr_sno;
  logic w_wr_lat;
  logic w_lat_ok;

  assign w_wr_wdt = bus.CE & bus.WR & bus.SEL_WDT;
  assign w_wr_srq = bus.CE & bus.WR & bus.SEL_SRQ;
  assign w_wr_sno = bus.CE & bus.WR & bus.SEL_SNO;
  assign w_wr_lat = bus.CE & bus.WR & bus.SEL_LAT;
  // Out-of-range indices (non-power-of-two LATCH_BITS) are dropped.
  assign w_lat_ok = ({1'b0, bus.LAT_AD} < (AW + 1)'(LATCH_BITS));

  // ---------------- control latch and sound number ----------------
  logic [LATCH_BITS-1:0] r_latch;
  logic [7:0]            r_sndno;

  // Addressable latch: one bit written from DIN[0] per latch write.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_latch <= '0;
    end else if (w_wr_lat && w_lat_ok) begin
      r_latch[bus.LAT_AD] <= bus.DIN[0];
    end
  end

  // Sound command byte mailbox.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sndno <= 8'h00;
    end else if (w_wr_sno) begin
      r_sndno <= bus.DIN;
    end
  end

  // ---------------- sound request ----------------
  logic r_sndrq;
  logic r_sndovf;

`ifdef MAIN_SNDACK_EN
  // Handshake level: a write sets it, ACK clears it, a write wins over ACK.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sndrq  <= 1'b0;
      r_sndovf <= 1'b0;
    end else if (bus.CE) begin
      if (w_wr_srq) begin
        r_sndrq <= 1'b1;
        if (r_sndrq) begin
          r_sndovf <= 1'b1;
        end
      end else if (bus.SNDACK) begin
        r_sndrq <= 1'b0;
      end
    end
  end
`else
  localparam logic [3:0] SRQ_LOAD = 4'(SNDRQ_LEN);

  logic [3:0] r_srq_cnt;
  logic [3:0] w_srq_cnt_nxt;

  // Pulse counter: reload on write (extends a running pulse), else count down.
  always_comb begin
    w_srq_cnt_nxt = r_srq_cnt;
    if (w_wr_srq) begin
      w_srq_cnt_nxt = SRQ_LOAD;
    end else if (r_srq_cnt != 4'd0) begin
      w_srq_cnt_nxt = r_srq_cnt - 4'd1;
    end else begin
      w_srq_cnt_nxt = 4'd0;
    end
  end

  // Pulse counter, registered request and sticky overflow.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_srq_cnt <= 4'd0;
      r_sndrq   <= 1'b0;
      r_sndovf  <= 1'b0;
    end else if (bus.CE) begin
      r_srq_cnt <= w_srq_cnt_nxt;
      r_sndrq   <= (w_srq_cnt_nxt != 4'd0);
      if (w_wr_srq && (r_srq_cnt != 4'd0)) begin
        r_sndovf <= 1'b1;
      end
    end
  end
`endif

  // ---------------- V-blank NMI ----------------
  logic w_mask;
  logic w_nmi_set;
  logic w_mask_fall;
  logic r_mask_q;
  logic r_pend;
  logic r_nmi;

  assign w_mask      = r_latch[NMI_MASK_BIT];
  assign w_nmi_set   = (bus.PV == 9'(NMI_LINE)) && (bus.PH == 9'd0);
  // r_mask_q lags the latch by one strike, so the fall is seen on the strike
  // after the mask write.
  assign w_mask_fall = r_mask_q & ~w_mask;

  // Pending flag (clear beats set) and registered NMI level.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mask_q <= 1'b0;
      r_pend   <= 1'b0;
      r_nmi    <= 1'b0;
    end else if (bus.CE) begin
      r_mask_q <= w_mask;
      r_pend   <= (r_pend | w_nmi_set) & ~w_mask_fall;
      r_nmi    <= r_pend & w_mask;
    end
  end

  // ---------------- watchdog ----------------
  logic w_wdt_rst;

  main_wdt #(
    .WDT_BITS    (WDT_BITS),
    .WDT_LIMIT   (WDT_LIMIT),
    .WDT_RST_LEN (WDT_RST_LEN)
  ) u_wdt (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .CE      (bus.CE),
    .KICK    (w_wr_wdt),
    .WDT_RST (w_wdt_rst)
  );

  assign bus.LATCH   = r_latch;
  assign bus.SNDNO   = r_sndno;
  assign bus.SNDRQ   = r_sndrq;
  assign bus.SNDOVF  = r_sndovf;
  assign bus.NMI     = r_nmi;
  assign bus.WDT_RST = w_wdt_rst;

endmodule
